// File: rtl/vram_pkg.sv
// vram_pkg: shared defaults and read-tag encoding for the canvas VRAM arbiter.
//   ADDRW_DEF / DATAW_DEF : default VRAM address and word widths
//   rd_tag_e              : read-return tag carried through the latency pipe
package vram_pkg;

    localparam int unsigned ADDRW_DEF = 14;
    localparam int unsigned DATAW_DEF = 32;

    typedef enum logic [1:0] {
        TAG_NONE = 2'b00,
        TAG_DISP = 2'b01,
        TAG_SYS  = 2'b10
    } rd_tag_e;

endpackage

// File: rtl/vram_tag_pipe.sv
// vram_tag_pipe: registered shift of read tags matching the VRAM read latency.
//   clk         : system clock
//   clr         : synchronous clear, drops all in-flight tags
//   tag_in      : tag of the read accepted this cycle (TAG_NONE if none)
//   disp_rvalid : display read data valid (registered)
//   sys_rvalid  : system read data valid (registered)
module vram_tag_pipe
    import vram_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic    clk,
    input  logic    clr,
    input  rd_tag_e tag_in,
    output logic    disp_rvalid,
    output logic    sys_rvalid
);

    rd_tag_e stage_q [DEPTH];
    rd_tag_e stage_d [DEPTH];

    // Shift toward the last stage; the last stage is the one whose data is on mem_rdata.
    always_comb begin
        stage_d[0] = tag_in;
        for (int unsigned i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (clr) begin
                stage_q[i] <= TAG_NONE;
            end else begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign disp_rvalid = (stage_q[DEPTH-1] == TAG_DISP);
    assign sys_rvalid  = (stage_q[DEPTH-1] == TAG_SYS);

endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares a single-port canvas VRAM between the real-time display
// fetch port (high priority, read-only) and the system port (read/write).
// A wait counter forces a system grant after MAX_WAIT stalled cycles.
//   clk, rst                      : clock, synchronous active-high reset
//   disp_req/addr/ack             : display request handshake (ack combinational)
//   disp_rvalid/rdata             : display read return, 2 cycles after ack
//   sys_req/we/addr/wdata/wmask   : system request
//   sys_ack                       : system accept (combinational)
//   sys_rvalid/rdata              : system read return, 2 cycles after ack
//   mem_addr/we/wdata             : registered VRAM command
//   mem_rdata                     : VRAM read data, one cycle after mem_addr
// Optional: define VRAM_ARB_STATS_EN to add stat_clr, stat_stall, stat_force.
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int unsigned ADDRW    = ADDRW_DEF,
    parameter int unsigned DATAW    = DATAW_DEF,
    parameter int unsigned MAX_WAIT = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               disp_req,
    input  logic [ADDRW-1:0]   disp_addr,
    output logic               disp_ack,
    output logic               disp_rvalid,
    output logic [DATAW-1:0]   disp_rdata,
    input  logic               sys_req,
    input  logic               sys_we,
    input  logic [ADDRW-1:0]   sys_addr,
    input  logic [DATAW-1:0]   sys_wdata,
    input  logic [DATAW/8-1:0] sys_wmask,
    output logic               sys_ack,
    output logic               sys_rvalid,
    output logic [DATAW-1:0]   sys_rdata,
`ifdef VRAM_ARB_STATS_EN
    input  logic               stat_clr,
    output logic [31:0]        stat_stall,
    output logic [31:0]        stat_force,
`endif
    output logic [ADDRW-1:0]   mem_addr,
    output logic [DATAW/8-1:0] mem_we,
    output logic [DATAW-1:0]   mem_wdata,
    input  logic [DATAW-1:0]   mem_rdata
);

    localparam int unsigned MASKW = DATAW / 8;
    localparam int unsigned CNTW  = $clog2(MAX_WAIT + 1);

    logic [CNTW-1:0]  wait_cnt_q,  wait_cnt_d;
    logic [ADDRW-1:0] mem_addr_q,  mem_addr_d;
    logic [MASKW-1:0] mem_we_q,    mem_we_d;
    logic [DATAW-1:0] mem_wdata_q, mem_wdata_d;
    logic             starve;
    rd_tag_e          tag_in;

    // Arbitration: display wins unless the system port has waited long enough.
    always_comb begin
        starve   = (wait_cnt_q >= CNTW'(MAX_WAIT));
        sys_ack  = ~rst & sys_req & (~disp_req | starve);
        disp_ack = ~rst & disp_req & ~sys_ack;
    end

    // Wait counter, saturating at MAX_WAIT (a grant always follows at that point).
    always_comb begin
        wait_cnt_d = '0;
        if (sys_req && !sys_ack) begin
            wait_cnt_d = starve ? wait_cnt_q : wait_cnt_q + CNTW'(1);
        end
    end

    // Command stage: winner's command is presented to VRAM the following cycle.
    always_comb begin
        mem_addr_d  = mem_addr_q;
        mem_we_d    = '0;
        mem_wdata_d = mem_wdata_q;
        tag_in      = TAG_NONE;
        if (sys_ack) begin
            mem_addr_d = sys_addr;
            if (sys_we) begin
                mem_we_d    = sys_wmask;
                mem_wdata_d = sys_wdata;
            end else begin
                tag_in = TAG_SYS;
            end
        end else if (disp_ack) begin
            mem_addr_d = disp_addr;
            tag_in     = TAG_DISP;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_q  <= '0;
            mem_addr_q  <= '0;
            mem_we_q    <= '0;
            mem_wdata_q <= '0;
        end else begin
            wait_cnt_q  <= wait_cnt_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    vram_tag_pipe #(
        .DEPTH (2)
    ) u_tag_pipe (
        .clk         (clk),
        .clr         (rst),
        .tag_in      (tag_in),
        .disp_rvalid (disp_rvalid),
        .sys_rvalid  (sys_rvalid)
    );

    assign mem_addr   = mem_addr_q;
    assign mem_we     = mem_we_q;
    assign mem_wdata  = mem_wdata_q;
    assign disp_rdata = mem_rdata;
    assign sys_rdata  = mem_rdata;

`ifdef VRAM_ARB_STATS_EN
    logic [31:0] stat_stall_q, stat_stall_d;
    logic [31:0] stat_force_q, stat_force_d;

    // Stall cycles and starvation-forced grants (a system ack while display asks).
    always_comb begin
        stat_stall_d = stat_stall_q;
        stat_force_d = stat_force_q;
        if (stat_clr) begin
            stat_stall_d = '0;
            stat_force_d = '0;
        end else begin
            if (sys_req && !sys_ack) begin
                stat_stall_d = stat_stall_q + 32'd1;
            end
            if (sys_ack && disp_req) begin
                stat_force_d = stat_force_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_stall_q <= '0;
            stat_force_q <= '0;
        end else begin
            stat_stall_q <= stat_stall_d;
            stat_force_q <= stat_force_d;
        end
    end

    assign stat_stall = stat_stall_q;
    assign stat_force = stat_force_q;
`endif

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares one single-port canvas VRAM (1-cycle synchronous read) between two requesters:
  - the display bitmap fetch port, which is real-time, read-only and high priority;
  - the system port, which reads and writes on behalf of the CPU or drawing engine.
- Sits between the canvas memory and the display pipeline.
- Display wins by default; a wait counter stops the system port from starving.

Parameters:
- ADDRW, 14, VRAM word address width.
- DATAW, 32, VRAM word width; must be a multiple of 8.
- MAX_WAIT, 16, cycles the system port may wait before it is granted over display. Range 1..255.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- disp_req  in  1  display read request
- disp_addr  in  ADDRW  display read address
- disp_ack  out  1  display request accepted this cycle (combinational)
- disp_rvalid  out  1  display read data valid
- disp_rdata  out  DATAW  display read data
- sys_req  in  1  system request
- sys_we  in  1  system write (1) / read (0)
- sys_addr  in  ADDRW  system address
- sys_wdata  in  DATAW  system write data
- sys_wmask  in  DATAW/8  system byte write enables
- sys_ack  out  1  system request accepted this cycle (combinational)
- sys_rvalid  out  1  system read data valid
- sys_rdata  out  DATAW  system read data
- mem_addr  out  ADDRW  VRAM address (registered)
- mem_we  out  DATAW/8  VRAM byte write enables (registered)
- mem_wdata  out  DATAW  VRAM write data (registered)
- mem_rdata  in  DATAW  VRAM read data, valid one cycle after mem_addr

Behaviour:
- Clock and reset:
  - Single clock domain, clk.
  - Synchronous active-high reset rst, sampled on the rising edge.
- Requester rules:
  - req, addr, we, wdata and wmask are held stable until ack.
  - A requester may drop req without ack; no penalty.
  - A single cycle with req=1 and ack=1 is one transaction.
- Arbitration, combinational, at most one ack per cycle:
  - starve = (wait_cnt >= MAX_WAIT).
  - sys_ack = sys_req & (~disp_req | starve).
  - disp_ack = disp_req & ~sys_ack.
- wait_cnt (width $clog2(MAX_WAIT+1), saturating):
  - Increments when sys_req & ~sys_ack.
  - Clears to 0 on sys_ack, or when sys_req=0.
- Command stage, registered; acked in cycle t, VRAM command in t+1:
  - mem_addr takes the winner's address.
  - mem_we = sys_we ? sys_wmask : 0 for a system ack; 0 for a display ack.
  - mem_wdata = sys_wdata for a system write.
  - With no ack: mem_we=0; mem_addr and mem_wdata hold their previous values.
- Read return, using a 2-bit tag pipeline (stage1, stage2 = {disp_read, sys_read}):
  - A read acked in cycle t gives rvalid=1 in cycle t+2.
  - Read latency is 2 cycles from ack.
  - disp_rdata and sys_rdata are both wired directly to mem_rdata; only the rvalid flags are qualified.
  - System writes produce no rvalid.
- Throughput:
  - One transaction per cycle, back-to-back, mixed requesters allowed.
  - disp_rvalid and sys_rvalid are never high in the same cycle.
- Reset values:
  - disp_rvalid=0, sys_rvalid=0, mem_we=0, mem_addr=0, mem_wdata=0, wait_cnt=0, tags cleared.
  - Resetting mid-operation drops in-flight reads; no rvalid is produced for them.
  - Requests asserted during rst are not acked, and both acks are forced to 0 while rst=1.
- Boundary cases:
  - sys_wmask=0 with sys_we=1: acked, no VRAM bytes change.
  - MAX_WAIT=1: the system port is granted at most every other cycle under continuous display load.
  - With both requesters continuous, grant pattern is MAX_WAIT display acks, then 1 system ack, repeating.

Optional Feature:
- Macro: VRAM_ARB_STATS_EN.
- When defined, adds outputs stat_stall (32 bits) and stat_force (32 bits):
  - stat_stall counts cycles with sys_req & ~sys_ack.
  - stat_force counts system acks granted by starve while disp_req=1.
  - Both are wrapping counters, reset to 0, and clear on input stat_clr (1 bit, synchronous).
- When undefined, these ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared package vram_pkg holds:
  - default ADDRW and DATAW;
  - the read-tag encoding: TAG_NONE=2'b00, TAG_DISP=2'b01, TAG_SYS=2'b10.
- Sub-module vram_tag_pipe: a parameterised-depth (2) registered tag shift with synchronous clear. It produces both rvalid flags.

Test Plan:
- Idle then single system read:
  - Stimulus: sys_req=1, sys_we=0, sys_addr=0x0010, VRAM[0x10]=0xDEADBEEF.
  - Response: sys_ack in cycle 0, mem_addr=0x0010 in cycle 1, sys_rvalid=1 with sys_rdata=0xDEADBEEF in cycle 2.
- Masked write:
  - Stimulus: sys_we=1, addr 0x0020, wdata 0x11223344, wmask 4'b0101, VRAM previously 0xAABBCCDD.
  - Response: read-back returns 0xAA22CC44.
- Contention (MAX_WAIT=16):
  - Stimulus: disp_req held high for 100 cycles with sequential addresses, and sys_req held high throughout.
  - Response: exactly one sys_ack every 17 cycles; disp_rvalid count = disp_ack count; rvalid flags never overlap.
- Display priority:
  - Stimulus: both requests rise in the same cycle with wait_cnt=0.
  - Response: disp_ack=1 and sys_ack=0; wait_cnt=1 next cycle.
- Reset mid-read:
  - Stimulus: display read acked, rst=1 on the following cycle.
  - Response: no disp_rvalid, mem_we=0, wait_cnt=0; normal operation resumes after rst=0.
- With VRAM_ARB_STATS_EN:
  - Stimulus: the contention scenario above, run for 34 cycles.
  - Response: stat_force=2, stat_stall=32; stat_clr returns both to 0 next cycle.
